// File: rtl/if_stage_pkg.sv
// Shared core definitions for the instruction fetch stage: FSM states,
// default boot address and PC arithmetic.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  // Sequential fetch step; wraps modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small power-of-two FIFO holding fetched {pc, instr} pairs.
// Flush empties it in one cycle; push and pop together on a full FIFO is legal.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory requester feeding a
// small buffer towards decode, with branch redirect and stale-response dropping.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        halt_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        valid_o,
  input  logic        ready_i
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW + 1)'(FIFO_DEPTH);

  fetch_state_t  state;
  logic [31:0]   fetch_pc;
  logic          drop;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [63:0]   head;
  logic [CW:0]   occ_next;
  logic          can_fetch;
  logic [31:0]   next_addr;

  assign push      = (state == WAIT) && mem_rvalid_i && !drop && !branch_i && (!full || pop);
  assign pop       = valid_o && ready_i && !branch_i;
  assign valid_o   = !empty;
  assign instr_o   = head[31:0];
  assign pc_o      = head[63:32];
  assign next_addr = branch_i ? branch_target_i : fetch_pc;

  // Occupancy after this edge; a new request is only issued if its response
  // is guaranteed a slot.
  always_comb begin
    occ_next = {1'b0, count};
    if (branch_i) begin
      occ_next = '0;
    end else begin
      if (push) occ_next = occ_next + (CW + 1)'(1);
      if (pop)  occ_next = occ_next - (CW + 1)'(1);
    end
    can_fetch = !halt_i && (occ_next < DEPTH_L);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst_i),
    .push  (push),
    .pop   (pop),
    .flush (branch_i),
    .wdata ({mem_addr_o, mem_rdata_i}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      fetch_pc   <= BOOT_ADDR;
      mem_addr_o <= BOOT_ADDR;
      mem_req_o  <= 1'b0;
      drop       <= 1'b0;
    end else begin
      if (branch_i) fetch_pc <= branch_target_i;
      unique case (state)
        IDLE: begin
          if (can_fetch) begin
            state      <= REQ;
            mem_req_o  <= 1'b1;
            mem_addr_o <= next_addr;
          end
        end
        REQ: begin
          // The old address must still be granted; its response is dropped later.
          if (branch_i) drop <= 1'b1;
          if (mem_gnt_i) begin
            state     <= WAIT;
            mem_req_o <= 1'b0;
            if (!branch_i && !drop) fetch_pc <= next_pc(mem_addr_o);
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            drop <= 1'b0;
            if (can_fetch) begin
              state      <= REQ;
              mem_req_o  <= 1'b1;
              mem_addr_o <= next_addr;
            end else begin
              state <= IDLE;
            end
          end else if (branch_i) begin
            drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed fetch scenarios plus a randomized
// phase, all checked against a program-order model with a behavioural memory.
module tb_if_stage;

  localparam logic [31:0] BOOT = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        halt_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        valid_o;
  logic        ready_i;

  int errors = 0;
  int checks = 0;

  // Stimulus knobs
  bit          ready_v, halt_v, br_v, hold_gnt, stray_rv;
  logic [31:0] tgt_v;
  int          gnt_pct, lat_min, lat_max, stray_pct;

  // Memory and program-order model
  bit          out_pend;
  logic [31:0] out_addr;
  int          rv_wait;
  logic [31:0] exp_pc;
  logic [31:0] grant_log[$];
  logic [31:0] deliv_log[$];
  bit          prev_req, prev_gnt, prev_halt, prev_branch;
  logic [31:0] prev_addr;

  if_stage dut (
    .clk             (clk),
    .rst_i           (rst_i),
    .halt_i          (halt_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_gnt_i       (mem_gnt_i),
    .mem_rvalid_i    (mem_rvalid_i),
    .mem_rdata_i     (mem_rdata_i),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1; halt_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; ready_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) #1; else begin @(posedge clk); #1; end
      checkOutput("rst_req", mem_req_o, 0);
      checkOutput("rst_addr", mem_addr_o, BOOT);
      checkOutput("rst_valid", valid_o, 0);
      checkOutput("rst_instr", instr_o, 0);
      checkOutput("rst_pc", pc_o, 0);
    end
    exp_pc = BOOT; out_pend = 0; rv_wait = 0;
    grant_log.delete(); deliv_log.delete();
    prev_req = 0; prev_gnt = 0; prev_halt = 0; prev_branch = 0; prev_addr = BOOT;
    br_v = 0; hold_gnt = 0;
    rst_i = 1'b0;
  endtask

  // One clock cycle: check observed state, model memory, drive inputs, advance.
  task automatic applyStimulus();
    logic        rv, g, was_pend;
    logic [31:0] rd;
    rv = 1'b0; g = 1'b0; rd = $urandom; was_pend = out_pend;
    if (prev_req && !prev_gnt) begin
      checkOutput("req_hold", mem_req_o, 1);
      checkOutput("addr_hold", mem_addr_o, prev_addr);
    end
    if (!prev_req && prev_halt) checkOutput("halt_inhibit", mem_req_o, 0);
    if (out_pend) checkOutput("one_outstanding", mem_req_o, 0);
    if (prev_branch) checkOutput("branch_flush", valid_o, 0);

    if (out_pend) begin
      if (rv_wait == 0) begin
        rv = 1'b1; rd = mem_data(out_addr); out_pend = 0;
      end else begin
        rv_wait--;
      end
    end else if (stray_rv || ($urandom_range(99) < stray_pct)) begin
      rv = 1'b1; rd = 32'hDEAD_BEEF; stray_rv = 0;
    end
    g = mem_req_o && !hold_gnt && !was_pend && ($urandom_range(99) < gnt_pct);
    if (g) begin
      out_pend = 1; out_addr = mem_addr_o;
      rv_wait = $urandom_range(lat_max, lat_min);
      grant_log.push_back(mem_addr_o);
    end

    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    ready_i = ready_v; halt_i = halt_v; branch_i = br_v; branch_target_i = tgt_v;

    if (valid_o && ready_v && !br_v) begin
      checkOutput("deliv_pc", pc_o, exp_pc);
      checkOutput("deliv_instr", instr_o, mem_data(exp_pc));
      deliv_log.push_back(pc_o);
      exp_pc = exp_pc + 32'd4;
    end
    if (br_v) exp_pc = tgt_v;

    prev_req = mem_req_o; prev_gnt = g; prev_addr = mem_addr_o;
    prev_halt = halt_v; prev_branch = br_v;
    @(posedge clk); #1;
  endtask

  initial begin
    int n, base, idx;
    logic [31:0] t;
    bit found;
    ready_v = 1; halt_v = 0; br_v = 0; tgt_v = '0; hold_gnt = 0; stray_rv = 0;
    gnt_pct = 100; lat_min = 0; lat_max = 0; stray_pct = 0;
    @(posedge clk); #1;

    // Back-to-back fetch from boot
    reset_dut();
    n = 0;
    while (deliv_log.size() < 3 && n < 40) begin applyStimulus(); n++; end
    checkOutput("t034_done", 32'(deliv_log.size() >= 3), 1);
    for (int i = 0; i < 3; i++) begin
      checkOutput("t034_req_addr", grant_log[i], 32'(i * 4));
      checkOutput("t034_pc", deliv_log[i], 32'(i * 4));
    end

    // Decode stalled: buffer fills, requests stop, nothing lost afterwards
    reset_dut();
    ready_v = 0;
    repeat (10) applyStimulus();
    checkOutput("t035_grants", 32'(grant_log.size()), 2);
    checkOutput("t035_req_low", mem_req_o, 0);
    checkOutput("t035_valid", valid_o, 1);
    ready_v = 1; n = 0;
    while (deliv_log.size() < 4 && n < 40) begin applyStimulus(); n++; end
    checkOutput("t035_done", 32'(deliv_log.size() >= 4), 1);
    for (int i = 0; i < 4; i++) checkOutput("t035_pc", deliv_log[i], 32'(i * 4));

    // Grant withheld: request held stable at 0x10
    reset_dut();
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h10) && n < 60) begin applyStimulus(); n++; end
    checkOutput("t036_reached", 32'(mem_req_o && mem_addr_o == 32'h10), 1);
    hold_gnt = 1;
    repeat (5) begin
      applyStimulus();
      checkOutput("t036_addr", mem_addr_o, 32'h10);
      checkOutput("t036_req", mem_req_o, 1);
    end
    hold_gnt = 0;

    // Branch while waiting on 0x14
    lat_min = 3; lat_max = 3; n = 0;
    while (!(out_pend && out_addr == 32'h14) && n < 40) begin applyStimulus(); n++; end
    checkOutput("t037_reached", 32'(out_pend && out_addr == 32'h14), 1);
    base = deliv_log.size();
    br_v = 1; tgt_v = 32'h200; applyStimulus(); br_v = 0;
    n = 0;
    while (deliv_log.size() <= base && n < 60) begin applyStimulus(); n++; end
    checkOutput("t037_pc", deliv_log[base], 32'h200);

    // Address wrap
    lat_min = 0; lat_max = 0;
    br_v = 1; tgt_v = 32'hFFFF_FFFC; applyStimulus(); br_v = 0;
    found = 0; idx = 0; n = 0;
    while (!found && n < 40) begin
      applyStimulus(); n++;
      for (int i = 0; i + 1 < grant_log.size(); i++)
        if (!found && grant_log[i] == 32'hFFFF_FFFC) begin found = 1; idx = i + 1; end
    end
    checkOutput("t038_found", 32'(found), 1);
    checkOutput("t038_wrap_addr", grant_log[idx], 32'h0);

    // Reset during WAIT, late response afterwards
    lat_min = 3; lat_max = 3; n = 0;
    while (!out_pend && n < 20) begin applyStimulus(); n++; end
    checkOutput("t039_in_wait", 32'(out_pend), 1);
    reset_dut();
    stray_rv = 1; lat_min = 0; lat_max = 0; n = 0;
    while (deliv_log.size() < 1 && n < 40) begin applyStimulus(); n++; end
    checkOutput("t039_first_req", grant_log[0], BOOT);
    checkOutput("t039_first_pc", deliv_log[0], BOOT);

    // Randomized traffic
    reset_dut();
    gnt_pct = 60; lat_min = 0; lat_max = 3; stray_pct = 5;
    for (int c = 0; c < 2000; c++) begin
      ready_v = ($urandom_range(99) < 70);
      halt_v  = ($urandom_range(99) < 10);
      if (!prev_branch && $urandom_range(99) < 4) begin
        t = $urandom;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFF0 | {28'd0, t[3:0]};
        br_v = 1; tgt_v = {t[31:2], 2'b00};
      end
      applyStimulus();
      br_v = 0;
    end
    checkOutput("rand_progress", 32'(deliv_log.size() > 100), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
